// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard tracker: tracker entry layout,
// default MDU latencies and the saturating tnew decrement.
package hazard_pkg;

    localparam int TNEW_W       = 3;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef struct packed {
        logic              valid;
        logic [4:0]        addr;
        logic [TNEW_W-1:0] tnew;
    } trk_entry_t;

    function automatic logic [TNEW_W-1:0] decTnew(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_mdu_timer.sv
// Self-timed HI/LO busy window: a mult/div accepted at D raises busy in E and
// keeps it up for the selected latency afterwards.
module hazard_mdu_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    input  logic issueDiv,
    output logic mduBusy
);

    localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic          startE;
    logic          divE;
    logic [CW-1:0] cnt;

    // The count starts once the op sits in E, so busy spans 1+latency cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            startE <= 1'b0;
            divE   <= 1'b0;
            cnt    <= '0;
        end else begin
            startE <= issue;
            divE   <= issueDiv;
            if (startE) begin
                cnt <= divE ? CW'(DIV_CYC) : CW'(MULT_CYC);
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign mduBusy = startE | (cnt != '0);

endmodule

// File: rtl/hazard_tracker.sv
// D-stage hazard controller: ages in-flight writers, raises stall and picks forward stages.
// Optional HI/LO busy tracking is enabled with the HAZARD_MDU_EN macro.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int NREAD    = 2,
    parameter int TW       = TNEW_W,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NREAD-1:0]                     rd_en,
    input  logic [5*NREAD-1:0]                   rd_addr,
    input  logic [TW*NREAD-1:0]                  t_use,
    input  logic                                 wr_en,
    input  logic [4:0]                           wr_addr,
    input  logic [TW-1:0]                        t_new,
    input  logic                                 md_start,
    input  logic                                 md_div,
    input  logic                                 md_use,
    input  logic                                 flush,
    output logic                                 stall,
    output logic [$clog2(NSTAGE+1)*NREAD-1:0]    fwd_sel,
    output logic                                 mdu_busy
);

    localparam int SW = $clog2(NSTAGE + 1);

    trk_entry_t entries [NSTAGE];
    logic       dataStall;

    // Shift register of writers; a stalled D injects a bubble while older entries keep aging.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSTAGE; i++) entries[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NSTAGE; i++) entries[i] <= '0;
        end else begin
            if (stall) begin
                entries[0] <= '0;
            end else begin
                entries[0].valid <= wr_en && (wr_addr != 5'd0);
                entries[0].addr  <= wr_addr;
                entries[0].tnew  <= TNEW_W'(t_new);
            end
            for (int i = 1; i < NSTAGE; i++) begin
                entries[i].valid <= entries[i-1].valid;
                entries[i].addr  <= entries[i-1].addr;
                entries[i].tnew  <= decTnew(entries[i-1].tnew);
            end
        end
    end

    // Scanning old-to-young lets the youngest match overwrite older ones.
    always_comb begin
        logic              hit;
        logic [TNEW_W-1:0] hitT;
        int                hitIdx;
        hit       = 1'b0;
        hitT      = '0;
        hitIdx    = 0;
        dataStall = 1'b0;
        fwd_sel   = '0;
        for (int r = 0; r < NREAD; r++) begin
            hit    = 1'b0;
            hitT   = '0;
            hitIdx = 0;
            for (int i = NSTAGE - 1; i >= 0; i--) begin
                if (rd_en[r] && (rd_addr[5*r +: 5] != 5'd0) && entries[i].valid &&
                    (entries[i].addr == rd_addr[5*r +: 5])) begin
                    hit    = 1'b1;
                    hitT   = entries[i].tnew;
                    hitIdx = i;
                end
            end
            if (hit && (TNEW_W'(t_use[TW*r +: TW]) < hitT)) dataStall = 1'b1;
            if (hit && (hitT == '0)) fwd_sel[SW*r +: SW] = SW'(hitIdx + 1);
        end
    end

`ifdef HAZARD_MDU_EN
    logic mduBusyInt;

    hazard_mdu_timer #(
        .MULT_CYC(MULT_CYC),
        .DIV_CYC (DIV_CYC)
    ) mduTimer (
        .clk     (clk),
        .reset   (reset),
        .issue   (md_start && !stall && !flush),
        .issueDiv(md_div),
        .mduBusy (mduBusyInt)
    );

    assign mdu_busy = mduBusyInt;
    assign stall    = dataStall | (md_use & mduBusyInt);
`else
    logic unusedMd;
    localparam int unusedLat = MULT_CYC + DIV_CYC;

    assign unusedMd = ^{md_start, md_div, md_use};
    assign mdu_busy = 1'b0;
    assign stall    = dataStall;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed pipeline scenarios followed by
// random traffic, both compared against a timestamp-based producer model.
module tb_hazard_tracker;

    localparam int NSTAGE   = 3;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
`ifdef HAZARD_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] rdEn;
    logic [9:0] rdAddr;
    logic [5:0] tUse;
    logic       wrEn;
    logic [4:0] wrAddr;
    logic [2:0] tNew;
    logic       mdStart;
    logic       mdDiv;
    logic       mdUse;
    logic       flush;
    logic       stall;
    logic [3:0] fwdSel;
    logic       mduBusy;

    hazard_tracker dut (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rdEn),
        .rd_addr (rdAddr),
        .t_use   (tUse),
        .wr_en   (wrEn),
        .wr_addr (wrAddr),
        .t_new   (tNew),
        .md_start(mdStart),
        .md_div  (mdDiv),
        .md_use  (mdUse),
        .flush   (flush),
        .stall   (stall),
        .fwd_sel (fwdSel),
        .mdu_busy(mduBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each producer is remembered by the cycle it entered E and the cycle its result is ready.
    typedef struct {
        int addr;
        int eCycle;
        int readyCycle;
    } prod_t;

    prod_t prods[$];
    int    cyc;
    int    busyFrom;
    int    busyTo;
    bit    expStall;
    int    checks;
    int    failures;

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [4:0] a0, input logic [2:0] u0,
                                 input logic [4:0] a1, input logic [2:0] u1, input logic we,
                                 input logic [4:0] wa, input logic [2:0] tn,
                                 input logic [2:0] md, input logic fl);
        rdEn    = en;
        rdAddr  = {a1, a0};
        tUse    = {u1, u0};
        wrEn    = we;
        wrAddr  = wa;
        tNew    = tn;
        mdStart = md[2];
        mdDiv   = md[1];
        mdUse   = md[0];
        flush   = fl;
    endtask

    task automatic nop();
        applyStimulus(2'b00, 5'd0, 3'd0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 3'b000, 1'b0);
    endtask

    task automatic checkOutput(input string tag);
        int expFwd[2];
        bit dStall;
        bit expBusy;
        dStall = 1'b0;
        for (int r = 0; r < 2; r++) begin
            int best;
            int rem;
            expFwd[r] = 0;
            best      = -1;
            if (rdEn[r] && rdAddr[5*r +: 5] != 5'd0) begin
                foreach (prods[k]) begin
                    if (prods[k].addr == int'(rdAddr[5*r +: 5]) &&
                        (best < 0 || prods[k].eCycle > prods[best].eCycle)) best = k;
                end
            end
            if (best >= 0) begin
                rem = prods[best].readyCycle - cyc;
                if (rem < 0) rem = 0;
                if (int'(tUse[3*r +: 3]) < rem) dStall = 1'b1;
                if (rem == 0) expFwd[r] = cyc - prods[best].eCycle + 1;
            end
        end
        expBusy  = MDU_EN && (cyc >= busyFrom) && (cyc <= busyTo);
        expStall = dStall | (expBusy & mdUse);
        checkVal({tag, ".stall"}, 8'(stall), 8'(expStall));
        checkVal({tag, ".fwd0"}, 8'(fwdSel[1:0]), 8'(expFwd[0]));
        checkVal({tag, ".fwd1"}, 8'(fwdSel[3:2]), 8'(expFwd[1]));
        checkVal({tag, ".busy"}, 8'(mduBusy), 8'(expBusy));
    endtask

    task automatic sample(input string tag);
        #4;
        checkOutput(tag);
    endtask

    task automatic finishCycle();
        prod_t p;
        @(posedge clk);
        if (flush) begin
            prods.delete();
        end else if (!expStall) begin
            if (wrEn && wrAddr != 5'd0) begin
                p.addr       = int'(wrAddr);
                p.eCycle     = cyc + 1;
                p.readyCycle = cyc + 1 + int'(tNew);
                prods.push_back(p);
            end
            if (MDU_EN && mdStart) begin
                busyFrom = cyc + 1;
                busyTo   = cyc + 1 + (mdDiv ? DIV_LAT : MULT_LAT);
            end
        end
        cyc++;
        for (int k = prods.size() - 1; k >= 0; k--) begin
            if (cyc - prods[k].eCycle >= NSTAGE) prods.delete(k);
        end
        #1;
    endtask

    initial begin
        int stallCount;
        int busyCount;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        busyFrom = 0;
        busyTo   = -1;
        reset    = 1'b0;
        nop();

        #2;
        checkVal("reset.stall", 8'(stall), 8'd0);
        checkVal("reset.fwd", 8'(fwdSel), 8'd0);
        checkVal("reset.busy", 8'(mduBusy), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] load-use and branch forwarding");
        applyStimulus(2'b00, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 5'd8, 3'd2, 3'b000, 1'b0);
        sample("luLw");
        finishCycle();
        applyStimulus(2'b01, 5'd8, 3'd1, 5'd0, 3'd0, 1'b1, 5'd10, 3'd1, 3'b000, 1'b0);
        sample("luUse");
        checkVal("luUse.stallConst", 8'(stall), 8'd1);
        finishCycle();
        sample("luUse2");
        checkVal("luUse2.stallConst", 8'(stall), 8'd0);
        finishCycle();
        applyStimulus(2'b11, 5'd10, 3'd0, 5'd8, 3'd0, 1'b0, 5'd0, 3'd0, 3'b000, 1'b0);
        sample("beq");
        checkVal("beq.stallConst", 8'(stall), 8'd1);
        checkVal("beq.fwdWConst", 8'(fwdSel[3:2]), 8'd3);
        finishCycle();
        sample("beq2");
        checkVal("beq2.stallConst", 8'(stall), 8'd0);
        checkVal("beq2.fwdMConst", 8'(fwdSel[1:0]), 8'd2);
        finishCycle();
        nop();
        for (int i = 0; i < 3; i++) begin
            sample("drain1");
            finishCycle();
        end

        $display("[TB] shadowing");
        applyStimulus(2'b00, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 5'd5, 3'd1, 3'b000, 1'b0);
        sample("shAddu");
        finishCycle();
        applyStimulus(2'b00, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 5'd5, 3'd2, 3'b000, 1'b0);
        sample("shLw");
        finishCycle();
        applyStimulus(2'b01, 5'd5, 3'd2, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 3'b000, 1'b0);
        sample("shRd1");
        checkVal("shRd1.stallConst", 8'(stall), 8'd0);
        checkVal("shRd1.fwdConst", 8'(fwdSel[1:0]), 8'd0);
        finishCycle();
        sample("shRd2");
        checkVal("shRd2.fwdConst", 8'(fwdSel[1:0]), 8'd0);
        finishCycle();
        sample("shRd3");
        checkVal("shRd3.fwdConst", 8'(fwdSel[1:0]), 8'd3);
        finishCycle();
        nop();
        for (int i = 0; i < 3; i++) begin
            sample("drain2");
            finishCycle();
        end

        $display("[TB] div then mflo");
        applyStimulus(2'b00, 5'd0, 3'd0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 3'b111, 1'b0);
        sample("div");
        finishCycle();
        stallCount = 0;
        busyCount  = 0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(2'b00, 5'd0, 3'd0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 3'b001, 1'b0);
            sample("mflo");
            stallCount += int'(stall);
            busyCount  += int'(mduBusy);
            finishCycle();
        end
        checkVal("mflo.stallCycles", 8'(stallCount), MDU_EN ? 8'd11 : 8'd0);
        checkVal("div.busyCycles", 8'(busyCount), MDU_EN ? 8'd11 : 8'd0);

        $display("[TB] flush");
        applyStimulus(2'b00, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 5'd3, 3'd2, 3'b000, 1'b0);
        sample("flLw");
        finishCycle();
        applyStimulus(2'b01, 5'd3, 3'd0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 3'b000, 1'b1);
        sample("flFlush");
        checkVal("flFlush.stallConst", 8'(stall), 8'd1);
        finishCycle();
        applyStimulus(2'b01, 5'd3, 3'd0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 3'b000, 1'b0);
        sample("flAfter");
        checkVal("flAfter.stallConst", 8'(stall), 8'd0);
        checkVal("flAfter.fwdConst", 8'(fwdSel[1:0]), 8'd0);
        finishCycle();

        $display("[TB] reset during mult");
        applyStimulus(2'b00, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 5'd7, 3'd3, 3'b101, 1'b0);
        sample("mult");
        finishCycle();
        applyStimulus(2'b01, 5'd7, 3'd0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 3'b000, 1'b0);
        sample("multRun");
        finishCycle();
        #2;
        reset = 1'b0;
        #1;
        checkVal("rstMid.busy", 8'(mduBusy), 8'd0);
        checkVal("rstMid.stall", 8'(stall), 8'd0);
        checkVal("rstMid.fwd", 8'(fwdSel), 8'd0);
        prods.delete();
        busyFrom = 0;
        busyTo   = -1;
        @(negedge clk);
        reset = 1'b1;
        nop();
        @(posedge clk);
        cyc++;
        #1;

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic ms;
            ms = ($urandom_range(0, 14) == 0);
            applyStimulus(2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          3'($urandom_range(0, 3)),
                          {ms, 1'($urandom_range(0, 1)), ms | ($urandom_range(0, 5) == 0)},
                          ($urandom_range(0, 19) == 0));
            sample("rnd");
            finishCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
